// File: rtl/pl_sysref_pkg.sv
// Shared types and default constants for the PL SYSREF synchroniser/gater.
// Holds the lock-tracking state enum and the period tolerance helper.
package pl_sysref_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_LOCK_COUNT  = 4;
    localparam int DEF_TOL         = 1;
    localparam int ERR_W           = 8;

    // Absolute difference without wrap: subtract the smaller from the larger.
    function automatic logic period_match(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] tol);
        return (a >= b) ? ((a - b) <= tol) : ((b - a) <= tol);
    endfunction

endpackage

// File: rtl/pl_sync_bit.sv
// Multi-flop bit synchroniser for an asynchronous single-bit input.
// The flops are tagged ASYNC_REG so placement keeps them adjacent.
module pl_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pl_sysref_sync.sv
// Synchronises pl_sysref, measures its period, locks onto a stable period and
// forwards whole SYSREF pulses to the enabled channels only while locked.
module pl_sysref_sync
    import pl_sysref_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int TOL         = DEF_TOL
) (
    input  logic              pl_clk,
    input  logic              pl_rst,
    input  logic              pl_sysref,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] sysref_out,
    output logic              sysref_rise,
    output logic              locked,
    output logic [CNT_W-1:0]  period_out,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               MC_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_COUNT);

    logic              w_sync;
    logic              r_sync_d;
    logic              w_rise;
    logic              r_rise_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_measured;
    logic              w_match;
    logic              w_timeout;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_period;
    logic [CNT_W-1:0]  w_period_nxt;
    logic [MC_W-1:0]   r_match_cnt;
    logic [MC_W-1:0]   w_match_cnt_nxt;
    logic [MC_W-1:0]   w_match_inc;
    logic [ERR_W-1:0]  r_err;
    logic [ERR_W-1:0]  w_err_nxt;
    logic [NUM_CH-1:0] w_gate_ld;
    logic [NUM_CH-1:0] r_gate;
    logic [NUM_CH-1:0] r_out;

    pl_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (pl_clk),
        .i_rst (pl_rst),
        .i_d   (pl_sysref),
        .o_q   (w_sync)
    );

    assign w_rise      = w_sync & ~r_sync_d;
    assign w_measured  = r_cnt + CNT_W'(1);
    assign w_match     = period_match(32'(w_measured), 32'(r_period), 32'(TOL));
    assign w_timeout   = (r_state != ST_IDLE) && (r_cnt == CNT_MAX);
    assign w_match_inc = r_match_cnt + MC_W'(1);

    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            r_sync_d <= 1'b0;
            r_rise_q <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync_d <= w_sync;
            r_rise_q <= w_rise;
            if (w_rise) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            r_state     <= ST_IDLE;
            r_period    <= '0;
            r_match_cnt <= '0;
            r_err       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_period    <= w_period_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_period_nxt    = r_period;
        w_match_cnt_nxt = r_match_cnt;
        w_err_nxt       = r_err;

        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end else if (w_rise) begin
            case (r_state)
                ST_MEASURE: begin
                    w_period_nxt    = w_measured;
                    w_match_cnt_nxt = '0;
                    w_state_nxt     = ST_TRACK;
                end
                ST_TRACK: begin
                    if (w_match) begin
                        w_match_cnt_nxt = w_match_inc;
                        if (w_match_inc == MC_LOCK) begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end else begin
                        w_period_nxt    = w_measured;
                        w_match_cnt_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!w_match) begin
                        if (r_err != '1) begin
                            w_err_nxt = r_err + ERR_W'(1);
                        end
                        w_period_nxt    = w_measured;
                        w_match_cnt_nxt = '0;
                        w_state_nxt     = ST_TRACK;
                    end
                end
                default: begin
                    w_state_nxt = ST_MEASURE;
                end
            endcase
        end
    end

    // Gate decision uses the pre-transition lock state, so the locking pulse is not forwarded.
    assign w_gate_ld = {NUM_CH{locked}} & ch_en;

    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            r_gate <= '0;
            r_out  <= '0;
        end else begin
            if (w_rise) begin
                r_gate <= w_gate_ld;
            end
            r_out <= {NUM_CH{w_sync}} & (w_rise ? w_gate_ld : r_gate);
        end
    end

    assign locked      = (r_state == ST_LOCKED);
    assign sysref_out  = r_out;
    assign sysref_rise = r_rise_q;
    assign period_out  = r_period;
    assign err_cnt     = r_err;

endmodule

// File: tb/tb_pl_sysref_sync.sv
// Self-checking bench for pl_sysref_sync: pulse-level reference model of the
// lock tracker, directed scenarios plus randomized periods/widths/enables.
module tb_pl_sysref_sync;

    localparam int NUM_CH = 2;
    localparam int SS     = 2;
    localparam int CNT_W  = 16;
    localparam int LOCK   = 4;
    localparam int TOL    = 1;
    localparam int LAT    = SS + 1;
    localparam int TMO    = LAT + (1 << CNT_W);

    localparam int P_IDLE    = 0;
    localparam int P_MEASURE = 1;
    localparam int P_TRACK   = 2;
    localparam int P_LOCKED  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              sysref;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] sysref_out;
    logic              sysref_rise;
    logic              locked;
    logic [CNT_W-1:0]  period_out;
    logic [7:0]        err_cnt;

    int errors = 0;
    int checks = 0;

    int m_phase;
    int m_period;
    int m_matches;
    int m_err;
    int m_gap;

    pl_sysref_sync #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SS),
        .CNT_W       (CNT_W),
        .LOCK_COUNT  (LOCK),
        .TOL         (TOL)
    ) dut (
        .pl_clk      (clk),
        .pl_rst      (rst),
        .pl_sysref   (sysref),
        .ch_en       (ch_en),
        .sysref_out  (sysref_out),
        .sysref_rise (sysref_rise),
        .locked      (locked),
        .period_out  (period_out),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_period  = 0;
        m_matches = 0;
        m_err     = 0;
        m_gap     = 0;
    endtask

    // One detected edge whose distance from the previous edge is 'gap' cycles.
    task automatic model_rise(input int gap);
        int  diff;
        bit  hit;
        diff = (gap >= m_period) ? gap - m_period : m_period - gap;
        hit  = (diff <= TOL);
        if (m_phase == P_IDLE) begin
            m_phase = P_MEASURE;
        end else if (m_phase == P_MEASURE) begin
            m_period  = gap;
            m_matches = 0;
            m_phase   = P_TRACK;
        end else if (m_phase == P_TRACK) begin
            if (hit) begin
                m_matches++;
                if (m_matches >= LOCK) m_phase = P_LOCKED;
            end else begin
                m_period  = gap;
                m_matches = 0;
            end
        end else if (!hit) begin
            if (m_err < 255) m_err++;
            m_period  = gap;
            m_matches = 0;
            m_phase   = P_TRACK;
        end
    endtask

    // One SYSREF pulse: high 'width' cycles, then low until 'period' cycles elapse.
    task automatic send_pulse(input int period, input int width,
                              input logic [1:0] en, input int toggle_c);
        logic [1:0] gate;
        logic [1:0] exp_out;
        gate = (m_phase == P_LOCKED) ? en : 2'b00;
        for (int c = 0; c < period; c++) begin
            @(negedge clk);
            if (c == LAT) model_rise(m_gap);
            if (c == TMO && m_phase != P_IDLE) m_phase = P_IDLE;
            exp_out = (c >= LAT && c < LAT + width) ? gate : 2'b00;
            check("locked", 32'(locked), 32'(m_phase == P_LOCKED));
            check("sysref_rise", 32'(sysref_rise), 32'(c == LAT));
            check("sysref_out", 32'(sysref_out), 32'(exp_out));
            if (c == period - 1) begin
                check("period_out", 32'(period_out), 32'(m_period));
                check("err_cnt", 32'(err_cnt), 32'(m_err));
            end
            sysref = (c < width);
            if (c == 0) ch_en = en;
            if (c == toggle_c) ch_en = ch_en ^ 2'b10;
        end
        m_gap = period;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out"}, 32'(sysref_out), 32'h0);
        check({tag, "_rise"}, 32'(sysref_rise), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
        check({tag, "_period"}, 32'(period_out), 32'h0);
        check({tag, "_err"}, 32'(err_cnt), 32'h0);
    endtask

    initial begin
        int per;
        int wid;
        int tog;
        logic [1:0] en;

        rst    = 1'b1;
        sysref = 1'b0;
        ch_en  = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Acquisition at period 32: lock after the 6th rise, forwarding from the 7th.
        for (int i = 0; i < 8; i++) begin
            send_pulse(32, 4, 2'b11, -1);
            if (i == 4) check("not_locked_5", 32'(locked), 32'h0);
            if (i == 5) check("locked_6", 32'(locked), 32'h1);
        end
        check("acq_period", 32'(period_out), 32'd32);

        // A single 35-cycle period breaks lock, then reacquisition at 32.
        send_pulse(35, 4, 2'b11, -1);
        send_pulse(32, 4, 2'b11, -1);
        check("slip_err", 32'(err_cnt), 32'd1);
        check("slip_locked", 32'(locked), 32'h0);
        check("slip_period", 32'(period_out), 32'd35);
        for (int i = 0; i < 6; i++) send_pulse(32, 4, 2'b11, -1);
        check("relock", 32'(locked), 32'h1);

        // Alternating 32/33 stays within tolerance.
        for (int i = 0; i < 8; i++) send_pulse((i % 2 == 1) ? 33 : 32, 4, 2'b11, -1);
        check("alt_locked", 32'(locked), 32'h1);
        check("alt_err", 32'(err_cnt), 32'd1);

        // ch_en[1] flipped mid-pulse takes effect only at the next rise.
        send_pulse(32, 4, 2'b11, 4);
        check("toggle_en", 32'(ch_en), 32'b01);
        send_pulse(32, 4, ch_en, 5);
        send_pulse(32, 4, ch_en, -1);

        // Randomized periods near lock, widths and enables.
        for (int i = 0; i < 40; i++) begin
            per = 30 + $urandom_range(0, 4);
            wid = $urandom_range(1, 8);
            en  = 2'($urandom_range(0, 3));
            tog = ($urandom_range(0, 1) == 1) ? $urandom_range(4, 12) : -1;
            send_pulse(per, wid, en, tog);
        end

        // Reacquire, then hold pl_sysref low until the period counter saturates.
        for (int i = 0; i < 8; i++) send_pulse(32, 4, 2'b11, -1);
        check("pre_tmo_locked", 32'(locked), 32'h1);
        send_pulse(TMO + 1, 4, 2'b11, -1);
        check("tmo_locked", 32'(locked), 32'h0);

        // Reacquire, then reset in the middle of a forwarded pulse.
        for (int i = 0; i < 8; i++) send_pulse(32, 4, 2'b11, -1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 5) check("rst_pre_out", 32'(sysref_out), 32'b11);
            sysref = (c < 4);
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            send_pulse(32, 4, 2'b11, -1);
            if (i == 4) check("post_rst_not_locked", 32'(locked), 32'h0);
            if (i == 5) check("post_rst_locked", 32'(locked), 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pl_sysref_sync.md
PL_SYSREF_SYNC -- requirements
Module: pl_sysref_sync

Interface
REQ-001 Parameter NUM_CH, default 2: number of gated SYSREF output channels (ADC/DAC tiles).
REQ-002 Parameter SYNC_STAGES, default 2, legal 2..4: synchroniser flops on pl_sysref.
REQ-003 Parameter CNT_W, default 16: width of the period counter and period_out.
REQ-004 Parameter LOCK_COUNT, default 4: consecutive matching periods required for lock.
REQ-005 Parameter TOL, default 1: allowed period deviation in pl_clk cycles (±).
REQ-006 pl_clk  input  1  PL clock, all logic on rising edge; one clock.
REQ-007 pl_rst  input  1  reset, asynchronous, active-high.
REQ-008 pl_sysref  input  1  single-ended SYSREF, already differential-buffered, asynchronous to pl_clk.
REQ-009 ch_en  input  NUM_CH  per-channel forward enable.
REQ-010 sysref_out  output  NUM_CH  gated, registered SYSREF per channel.
REQ-011 sysref_rise  output  1  one-cycle pulse per detected rising edge.
REQ-012 locked  output  1  high while state is LOCKED.
REQ-013 period_out  output  CNT_W  last captured period in pl_clk cycles.
REQ-014 err_cnt  output  8  saturating count of period mismatches while LOCKED.

Function
REQ-015 pl_sysref SHALL pass through SYNC_STAGES flops (sync) then one delay flop (sync_d); rise = sync & ~sync_d.
REQ-016 sysref_rise SHALL be registered rise; asserted SYNC_STAGES+1 cycles after the pl_sysref edge is first sampled.
REQ-017 Counter cnt SHALL clear to 0 on a rise cycle, otherwise increment, saturating at 2^CNT_W-1.
REQ-018 Measured period on a rise cycle SHALL be cnt+1 (edges 8 cycles apart -> 8).
REQ-019 Match SHALL mean |measured - period_out| <= TOL, unsigned compare without wrap.
REQ-020 States IDLE, MEASURE, TRACK, LOCKED; IDLE -> MEASURE on first rise.
REQ-021 MEASURE -> TRACK on next rise; period_out <= measured, match count <= 0.
REQ-022 TRACK, rise with match: match count +1; reaching LOCK_COUNT -> LOCKED.
REQ-023 TRACK, rise without match: period_out <= measured, match count <= 0, stay TRACK.
REQ-024 LOCKED, rise without match: err_cnt +1 (saturate at 255), period_out <= measured, -> TRACK.
REQ-025 Any state except IDLE: cnt reaching saturation SHALL force IDLE the next cycle; timeout has priority over a simultaneous rise.
REQ-026 Per-channel gate_q[i] SHALL load (locked & ch_en[i]) only on rise cycles, hold otherwise; ch_en changes mid-pulse SHALL NOT truncate or create a pulse.
REQ-027 sysref_out[i] SHALL register sync & (rise ? (locked & ch_en[i]) : gate_q[i]); latency pl_sysref -> sysref_out is SYNC_STAGES+1 cycles.
REQ-028 locked SHALL use its pre-transition value when gating the same-cycle rise; the pulse that completes lock is not forwarded.
REQ-029 Leaving LOCKED SHALL not cut a pulse in progress; gate updates at the next rise.

Reset
REQ-030 pl_rst SHALL asynchronously clear all flops: state IDLE, sysref_out 0, sysref_rise 0, locked 0, period_out 0, err_cnt 0, cnt 0, gate_q 0.
REQ-031 Reset mid-pulse SHALL drop sysref_out immediately; after release, reacquisition restarts from IDLE.
REQ-032 err_cnt SHALL clear only on reset.

Structure
REQ-033 Package pl_sysref_pkg SHALL hold the state enum and default parameter constants.
REQ-034 Sub-module pl_sync_bit (SYNC_STAGES-deep bit synchroniser with ASYNC_REG attribute) SHALL be instantiated once.
REQ-035 No vendor primitives inside pl_sysref_sync; IBUFDS/BUFGCE stay at top level.

Verification
REQ-036 Periodic pl_sysref, period 32, high 4, ch_en=2'b11 -> locked after 6th rise, period_out=32, sysref_out forwarded from 7th pulse, 4 cycles wide, latency 3.
REQ-037 Locked, one period 35 (TOL=1) -> err_cnt=1, locked drops, period_out=35, relock after LOCK_COUNT matching periods at 32.
REQ-038 Locked, period alternates 32/33 -> stays locked, err_cnt=0.
REQ-039 Locked, pl_sysref stuck low -> IDLE, locked=0 when cnt reaches 65535.
REQ-040 Locked, ch_en[1] toggled mid-pulse -> channel 1 pulse unchanged; change effective at next rise.
REQ-041 pl_rst asserted mid-pulse while locked -> all outputs 0 same cycle; after release relock takes 6 rises.
